fetch_stage: RTL and testbench

//  - IF stage of the MIPS pipeline; sits directly upstream of ID.
//  - Keeps the PC and issues in-order requests to instruction memory over a req/gnt + rvalid handshake.
//  - Buffers returned words in a small FIFO and drives the IF/ID pipeline register (inst_id, pc_id).
//  - Obeys ID's stall (hold_pc/hold_if) and branch/jump redirect (br/pc_branch); no delay slot.

---
 rtl/mips_pkg.sv | 12 +
 rtl/fetch_inst_fifo.sv | 56 +++++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Types and constants shared by the MIPS pipeline stages.
package mips_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   // One buffered fetch result; room for exception bits later.
   typedef struct packed {
      logic [31:0] inst;
   } if_entry_t;

endpackage

// File: rtl/fetch_inst_fifo.sv
// Small synchronous FIFO holding fetched instruction words until ID consumes them.
module fetch_inst_fifo
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         clear_i,
   input  if_entry_t                    data_i,
   output if_entry_t                    head_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_q, rd_q;
   logic [CW-1:0]     cnt_q;
   logic              do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // clear wins over push; a push into a full FIFO is dropped
   assign do_push = push_i && !clear_i && !full_o;
   assign do_pop  = pop_i && !clear_i && !empty_o;

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= ptr_inc(wr_q);
         if (do_pop)  rd_q <= ptr_inc(rd_q);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, in-order imem requests, response buffering and the IF/ID register.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold_pc,
   input  logic        hold_if,
   input  logic        br,
   input  logic [31:0] pc_branch,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_id,
   output logic [31:0] pc_id,
   output logic        flush_id
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   logic [31:0]   pc_q, pc_d, pc_dlv_q, pc_dlv_d;
   logic [31:0]   inst_q, inst_d, pc_id_q, pc_id_d;
   logic          flush_q, flush_d;
   logic [CW-1:0] out_q, out_d, disc_q, disc_d, fifo_cnt;
   logic [SW-1:0] inflight;
   logic          fifo_empty, fifo_full, grant, accept, push, pop;
   logic [31:0]   word;
   if_entry_t     head, push_data;

   // in-flight plus buffered words may never exceed the buffer size
   assign inflight  = SW'(out_q) + SW'(fifo_cnt);
   assign imem_req  = !rst && !hold_pc && !br && (inflight < SW'(FIFO_DEPTH));
   assign imem_addr = pc_q;
   assign grant     = imem_req && imem_gnt;

   assign accept         = imem_rvalid && (disc_q == '0);
   assign pop            = !br && !hold_if && !fifo_empty;
   assign push           = accept && !br && !(fifo_empty && !hold_if);
   assign push_data.inst = imem_rdata;
   assign word           = fifo_empty ? imem_rdata : head.inst;

   fetch_inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .clear_i (br),
      .data_i  (push_data),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_comb begin
      pc_d     = pc_q;
      pc_dlv_d = pc_dlv_q;
      inst_d   = inst_q;
      pc_id_d  = pc_id_q;
      flush_d  = flush_q;
      out_d    = out_q + CW'(grant) - CW'(imem_rvalid);
      disc_d   = disc_q;
      if (imem_rvalid && (disc_q != '0)) disc_d = disc_q - CW'(1);
      if (grant) pc_d = pc_q + PC_STEP;

      // redirect drops everything still owed by imem
      if (br) begin
         inst_d   = NOP_INST;
         flush_d  = 1'b1;
         pc_d     = pc_branch;
         pc_dlv_d = pc_branch;
         disc_d   = out_q + CW'(grant) - CW'(imem_rvalid);
      end else if (!hold_if) begin
         if (!fifo_empty || accept) begin
            inst_d   = word;
            pc_id_d  = pc_dlv_q + PC_STEP;
            pc_dlv_d = pc_dlv_q + PC_STEP;
            flush_d  = 1'b0;
         end else begin
            inst_d  = NOP_INST;
            flush_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         pc_dlv_q <= RESET_PC;
         inst_q   <= NOP_INST;
         pc_id_q  <= RESET_PC;
         flush_q  <= 1'b0;
         out_q    <= '0;
         disc_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         pc_dlv_q <= pc_dlv_d;
         inst_q   <= inst_d;
         pc_id_q  <= pc_id_d;
         flush_q  <= flush_d;
         out_q    <= out_d;
         disc_q   <= disc_d;
      end
   end

   assign inst_id  = inst_q;
   assign pc_id    = pc_id_q;
   assign flush_id = flush_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table plus scoreboard against an in-order imem model.
module tb_fetch_stage;
   import mips_pkg::*;

   localparam logic [31:0] RPC = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst, hold_pc, hold_if, br, imem_gnt, imem_rvalid;
   logic        imem_req, flush_id;
   logic [31:0] pc_branch, imem_addr, imem_rdata, inst_id, pc_id;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .hold_pc(hold_pc), .hold_if(hold_if), .br(br),
      .pc_branch(pc_branch), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_id(inst_id), .pc_id(pc_id), .flush_id(flush_id)
   );

   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;
   typedef struct {
      logic gnt; logic req; logic [31:0] addr; logic [31:0] inst; logic [31:0] pc; logic flush;
   } vec_t;

   pend_t pend[$];
   exp_t  expq[$];
   vec_t  tab[12];
   int    checks = 0, failures = 0, cyc = 0, lat = 1;
   logic  s_rst, s_br, s_hold, s_grant, s_rvalid, l_flush, seen;
   logic [31:0] s_addr, l_inst, l_pc;

   // never returns zero for a word-aligned address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic to_negedge();
      @(negedge clk);
      s_rst = rst; s_br = br; s_hold = hold_if; s_addr = imem_addr;
      s_grant = imem_req && imem_gnt; s_rvalid = imem_rvalid;
      l_inst = inst_id; l_pc = pc_id; l_flush = flush_id;
      if (rst) chk("req_in_reset", 32'(imem_req), 32'd0);
      if (br)  chk("req_during_br", 32'(imem_req), 32'd0);
   endtask

   task automatic to_posedge();
      @(posedge clk);
      #1;
      cyc++;
      if (s_rst) begin
         chk("rst_inst", inst_id, NOP_INST);
         chk("rst_pc_id", pc_id, RPC);
         chk("rst_flush", 32'(flush_id), 32'd0);
         expq.delete();
         pend.delete();
      end else begin
         if (s_br) begin
            chk("br_inst", inst_id, NOP_INST);
            chk("br_flush", 32'(flush_id), 32'd1);
            chk("br_pc_id", pc_id, l_pc);
            expq.delete();
         end else if (s_hold) begin
            chk("hold_inst", inst_id, l_inst);
            chk("hold_pc_id", pc_id, l_pc);
            chk("hold_flush", 32'(flush_id), 32'(l_flush));
         end else if (inst_id != NOP_INST) begin
            if (expq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_word: got %h expected none (cycle %0d)", inst_id, cyc);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("sb_inst", inst_id, e.inst);
               chk("sb_pc_id", pc_id, e.pc);
            end
            chk("word_flush", 32'(flush_id), 32'd0);
         end else begin
            chk("bubble_flush", 32'(flush_id), 32'd0);
            chk("bubble_pc_id", pc_id, l_pc);
         end
         if (s_rvalid && pend.size() > 0) void'(pend.pop_front());
         if (s_grant) begin
            pend.push_back('{s_addr, cyc + lat});
            expq.push_back('{mem(s_addr), s_addr + 32'd4});
         end
      end
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem(pend[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
   endtask

   task automatic tick();
      to_negedge();
      to_posedge();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      // free run from a wrapping reset PC, then 5 cycles without grant
      tab[0]  = '{1'b1, 1'b1, 32'hFFFF_FFF8, NOP_INST,           32'hFFFF_FFF8, 1'b0};
      tab[1]  = '{1'b1, 1'b1, 32'hFFFF_FFFC, NOP_INST,           32'hFFFF_FFF8, 1'b0};
      tab[2]  = '{1'b1, 1'b1, 32'h0000_0000, mem(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1'b0};
      tab[3]  = '{1'b1, 1'b1, 32'h0000_0004, mem(32'hFFFF_FFFC), 32'h0000_0000, 1'b0};
      tab[4]  = '{1'b0, 1'b1, 32'h0000_0008, mem(32'h0000_0000), 32'h0000_0004, 1'b0};
      tab[5]  = '{1'b0, 1'b1, 32'h0000_0008, mem(32'h0000_0004), 32'h0000_0008, 1'b0};
      tab[6]  = '{1'b0, 1'b1, 32'h0000_0008, NOP_INST,           32'h0000_0008, 1'b0};
      tab[7]  = '{1'b0, 1'b1, 32'h0000_0008, NOP_INST,           32'h0000_0008, 1'b0};
      tab[8]  = '{1'b0, 1'b1, 32'h0000_0008, NOP_INST,           32'h0000_0008, 1'b0};
      tab[9]  = '{1'b1, 1'b1, 32'h0000_0008, NOP_INST,           32'h0000_0008, 1'b0};
      tab[10] = '{1'b1, 1'b1, 32'h0000_000C, NOP_INST,           32'h0000_0008, 1'b0};
      tab[11] = '{1'b1, 1'b1, 32'h0000_0010, mem(32'h0000_0008), 32'h0000_000C, 1'b0};

      rst = 1'b1; hold_pc = 1'b0; hold_if = 1'b0; br = 1'b0; pc_branch = 32'h0;
      imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      repeat (2) tick();
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         imem_gnt = tab[i].gnt;
         to_negedge();
         chk($sformatf("tab%0d_req", i),   32'(imem_req), 32'(tab[i].req));
         chk($sformatf("tab%0d_addr", i),  imem_addr,     tab[i].addr);
         chk($sformatf("tab%0d_inst", i),  inst_id,       tab[i].inst);
         chk($sformatf("tab%0d_pc", i),    pc_id,         tab[i].pc);
         chk($sformatf("tab%0d_flush", i), 32'(flush_id), 32'(tab[i].flush));
         to_posedge();
      end

      // ID stall: the buffer fills and requests stop
      repeat (2) tick();
      hold_if = 1'b1;
      tick();
      to_negedge(); chk("hold_req_drop1", 32'(imem_req), 32'd0); to_posedge();
      to_negedge(); chk("hold_req_drop2", 32'(imem_req), 32'd0); to_posedge();
      hold_if = 1'b0;
      repeat (4) tick();

      // redirect with words in flight
      lat = 2;
      repeat (4) tick();
      br = 1'b1; pc_branch = 32'h0000_0040;
      tick();
      br = 1'b0;
      to_negedge();
      chk("post_br_flush", 32'(flush_id), 32'd1);
      chk("post_br_addr", imem_addr, 32'h0000_0040);
      to_posedge();
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         to_negedge();
         if (inst_id != NOP_INST) begin
            seen = 1'b1;
            chk("br_first_inst", inst_id, mem(32'h0000_0040));
            chk("br_first_pc_id", pc_id, 32'h0000_0044);
         end
         to_posedge();
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL br_first_word: got none expected %h within 20 cycles", mem(32'h40));
      end

      // reset mid-stream with requests outstanding
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lat = 1;
      to_negedge();
      chk("rst_restart_req", 32'(imem_req), 32'd1);
      chk("rst_restart_addr", imem_addr, RPC);
      to_posedge();
      repeat (6) tick();

      // drain: everything granted must have been delivered exactly once
      hold_pc = 1'b1;
      repeat (8) tick();
      chk("drain_expected_empty", 32'(expq.size()), 32'd0);
      chk("drain_pending_empty", 32'(pend.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
